// File: rtl/sram_model_pkg.sv
// Shared types, limits and address helpers for the multi-port SRAM model.
package sram_model_pkg;

  typedef enum logic {
    RDW_OLD,
    RDW_NEW
  } rdw_mode_e;

  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned NRD_MAX    = 4;
  localparam int unsigned ADDR_MAX   = 64;

  // In range when nothing is set above the word-index field and the index is below words.
  function automatic logic addr_in_range(input logic [ADDR_MAX-1:0] addr,
                                         input int unsigned         blsb,
                                         input int unsigned         idx_bits,
                                         input int unsigned         words);
    logic [ADDR_MAX-1:0] idx_mask;
    logic [ADDR_MAX-1:0] idx;
    idx_mask = (ADDR_MAX'(1) << idx_bits) - ADDR_MAX'(1);
    idx      = (addr >> blsb) & idx_mask;
    return ((addr >> (blsb + idx_bits)) == '0) && (idx < ADDR_MAX'(words));
  endfunction

endpackage

// File: rtl/spsram_mp_model_if.sv
// Bus bundle for spsram_mp_model: one read/write port A plus NRD packed read-only ports.
interface spsram_mp_model_if #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned NRD    = 1
);

  logic                          a_en;
  logic                          a_wr_en;
  logic [AWIDTH-1:0]             a_addr;
  logic [DWIDTH-1:0]             a_wdata;
  logic [DWIDTH/8-1:0]           a_mask;
  logic [DWIDTH-1:0]             a_rdata;
  logic                          a_rvalid;
  logic                          a_err;

  logic [NRD-1:0]                r_en;
  logic [NRD*AWIDTH-1:0]         r_addr;
  logic [NRD*(DWIDTH/8)-1:0]     r_mask;
  logic [NRD*DWIDTH-1:0]         r_rdata;
  logic [NRD-1:0]                r_rvalid;
  logic [NRD-1:0]                r_err;

  modport master (
    output a_en, a_wr_en, a_addr, a_wdata, a_mask, r_en, r_addr, r_mask,
    input  a_rdata, a_rvalid, a_err, r_rdata, r_rvalid, r_err
  );

  modport slave (
    input  a_en, a_wr_en, a_addr, a_wdata, a_mask, r_en, r_addr, r_mask,
    output a_rdata, a_rvalid, a_err, r_rdata, r_rvalid, r_err
  );

endinterface

// File: rtl/sram_rd_pipe.sv
// RD_LAT-deep {valid, err, data} delay line; data stages load only on valid so the output holds.
module sram_rd_pipe #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_err,
  input  logic [DWIDTH-1:0] i_data,
  output logic              o_valid,
  output logic              o_err,
  output logic [DWIDTH-1:0] o_data
);

  logic              r_valid [RD_LAT];
  logic              r_err   [RD_LAT];
  logic [DWIDTH-1:0] r_data  [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        r_valid[i] <= 1'b0;
        r_err[i]   <= 1'b0;
        r_data[i]  <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_err[0]   <= i_valid & i_err;
      if (i_valid) begin
        r_data[0] <= i_data;
      end
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_err[i]   <= r_err[i-1];
        if (r_valid[i-1]) begin
          r_data[i] <= r_data[i-1];
        end
      end
    end
  end

  assign o_valid = r_valid[RD_LAT-1];
  assign o_err   = r_err[RD_LAT-1];
  assign o_data  = r_data[RD_LAT-1];

endmodule

// File: rtl/spsram_mp_model.sv
// Behavioural SRAM: one read/write port A plus NRD read-only ports, fixed read latency.
module spsram_mp_model
  import sram_model_pkg::*;
#(
  parameter int unsigned WORDS        = 4096,
  parameter int unsigned AWIDTH       = 32,
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned NRD          = 1,
  parameter int unsigned RD_LAT       = 1,
  parameter bit          MASK_WR_ONLY = 1'b0,
  parameter rdw_mode_e   RDW_MODE     = RDW_OLD
) (
  input logic              clk,
  input logic              rst,
  spsram_mp_model_if.slave bus
);

  localparam int unsigned NB   = DWIDTH / 8;
  localparam int unsigned BLSB = $clog2(NB);
  localparam int unsigned D    = (WORDS > 1) ? $clog2(WORDS) : 1;

  if (DWIDTH % 8 != 0 || DWIDTH < 8 || DWIDTH > 128) begin : g_bad_dwidth
    $error("spsram_mp_model: DWIDTH must be a multiple of 8 in 8..128");
  end
  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("spsram_mp_model: RD_LAT must be in 1..4");
  end
  if (NRD < 1 || NRD > NRD_MAX) begin : g_bad_nrd
    $error("spsram_mp_model: NRD must be in 1..4");
  end
  if (AWIDTH < BLSB + D || AWIDTH > ADDR_MAX) begin : g_bad_awidth
    $error("spsram_mp_model: AWIDTH too narrow for WORDS or wider than 64");
  end

  logic [DWIDTH-1:0] MEM [WORDS];

  function automatic logic [DWIDTH-1:0] byte_mask(input logic [NB-1:0] m);
    logic [DWIDTH-1:0] res;
    for (int unsigned b = 0; b < NB; b++) begin
      res[b*8 +: 8] = {8{m[b]}};
    end
    return res;
  endfunction

  logic [D-1:0]      w_a_idx;
  logic              w_a_ok;
  logic              w_a_wr;
  logic              w_a_rd;
  logic [DWIDTH-1:0] w_a_data;
  logic              w_a_perr;
  logic              r_a_werr;

  assign w_a_idx = bus.a_addr[BLSB +: D];
  assign w_a_ok  = addr_in_range(ADDR_MAX'(bus.a_addr), BLSB, D, WORDS);
  assign w_a_wr  = bus.a_en & bus.a_wr_en & w_a_ok & ~rst;
  assign w_a_rd  = bus.a_en & ~bus.a_wr_en;

  always_ff @(posedge clk) begin
    if (w_a_wr) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (bus.a_mask[b]) begin
          MEM[w_a_idx][b*8 +: 8] <= bus.a_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_werr <= 1'b0;
    end else begin
      r_a_werr <= bus.a_en & bus.a_wr_en & ~w_a_ok;
    end
  end

  always_comb begin
    w_a_data = '0;
    if (w_a_ok) begin
      w_a_data = MASK_WR_ONLY ? MEM[w_a_idx] : (MEM[w_a_idx] & byte_mask(bus.a_mask));
    end
  end

  sram_rd_pipe #(
    .DWIDTH (DWIDTH),
    .RD_LAT (RD_LAT)
  ) u_a_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_a_rd),
    .i_err   (~w_a_ok),
    .i_data  (w_a_data),
    .o_valid (bus.a_rvalid),
    .o_err   (w_a_perr),
    .o_data  (bus.a_rdata)
  );

  assign bus.a_err = w_a_perr | r_a_werr;

  for (genvar p = 0; p < NRD; p++) begin : g_rport
    logic [AWIDTH-1:0] w_addr;
    logic [NB-1:0]     w_mask;
    logic [D-1:0]      w_idx;
    logic              w_ok;
    logic [DWIDTH-1:0] w_word;
    logic [DWIDTH-1:0] w_data;

    assign w_addr = bus.r_addr[p*AWIDTH +: AWIDTH];
    assign w_mask = bus.r_mask[p*NB +: NB];
    assign w_idx  = w_addr[BLSB +: D];
    assign w_ok   = addr_in_range(ADDR_MAX'(w_addr), BLSB, D, WORDS);

    // The array still holds pre-write contents this cycle, so RDW_OLD needs no bypass.
    always_comb begin
      w_word = MEM[w_idx];
      if (RDW_MODE == RDW_NEW && w_a_wr && (w_a_idx == w_idx)) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (bus.a_mask[b]) begin
            w_word[b*8 +: 8] = bus.a_wdata[b*8 +: 8];
          end
        end
      end
      w_data = '0;
      if (w_ok) begin
        w_data = MASK_WR_ONLY ? w_word : (w_word & byte_mask(w_mask));
      end
    end

    sram_rd_pipe #(
      .DWIDTH (DWIDTH),
      .RD_LAT (RD_LAT)
    ) u_r_pipe (
      .clk     (clk),
      .rst     (rst),
      .i_valid (bus.r_en[p]),
      .i_err   (~w_ok),
      .i_data  (w_data),
      .o_valid (bus.r_rvalid[p]),
      .o_err   (bus.r_err[p]),
      .o_data  (bus.r_rdata[p*DWIDTH +: DWIDTH])
    );
  end

endmodule

// File: doc/spsram_mp_model.md
Name: spsram_mp_model

Overview:
- Parametrised behavioural SRAM model; successor to the single-port model with its negedge side-read port.
- One read/write port (A) plus NRD read-only ports (R), all posedge-clocked.
- Configurable data width, depth, read latency and read-during-write mode; per-port read-valid and range-error flags.
- Backs instruction/data memory and accelerator (MAC) operand fetch in simulation.

Parameters:
- WORDS, 4096, number of data words; need not be a power of two.
- AWIDTH, 32, byte-address width for all ports.
- DWIDTH, 32, data width in bits; multiple of 8, 8..128.
- NRD, 1, number of read-only ports, 1..4.
- RD_LAT, 1, read latency in cycles, 1..4, same for all ports.
- MASK_WR_ONLY, 0, 1 = byte mask applies to writes only; reads return the full word.
- RDW_MODE, RDW_OLD, read-during-write data for same-word collisions (RDW_OLD / RDW_NEW).

Ports:
- clk  in  1  clock, all activity on posedge
- rst  in  1  synchronous active-high reset
- a_en  in  1  port A access request
- a_wr_en  in  1  1 = write, 0 = read (qualified by a_en)
- a_addr  in  AWIDTH  port A byte address
- a_wdata  in  DWIDTH  write data
- a_mask  in  DWIDTH/8  byte enables
- a_rdata  out  DWIDTH  read data
- a_rvalid  out  1  a_rdata valid, one-cycle pulse per read
- a_err  out  1  out-of-range flag, aligned with a_rvalid or with write completion
- r_en  in  NRD  per-port read request
- r_addr  in  NRD*AWIDTH  packed byte addresses, port i at [i*AWIDTH +: AWIDTH]
- r_mask  in  NRD*DWIDTH/8  packed byte enables
- r_rdata  out  NRD*DWIDTH  packed read data
- r_rvalid  out  NRD  per-port valid
- r_err  out  NRD  per-port out-of-range flag

Behaviour:
- Word index = addr[BLSB +: D], with BLSB = clog2(DWIDTH/8) and D = clog2(WORDS). Low BLSB bits are ignored.
- Out of range: upper address bits above BLSB+D are nonzero, or index >= WORDS.
- Write: on the posedge with a_en & a_wr_en, byte b is updated iff a_mask[b]. Updated bytes are visible to any read issued on a later cycle.
  - Out-of-range write: no update; a_err pulses the next cycle; a_rvalid stays 0.
- Read, on any port: an accepted request at cycle N gives rvalid=1 with data at cycle N+RD_LAT, exactly one cycle wide.
  - Back-to-back reads are fully pipelined, one per cycle per port, with no stalls.
- Read masking: when MASK_WR_ONLY=0, bytes with mask=0 return 8'h00 (deterministic, never X). When MASK_WR_ONLY=1, all bytes are returned.
- Out-of-range read: rvalid=1, err=1, data=0, at the normal latency.
- Same-word collision (A write with an R-port read, same cycle):
  - RDW_OLD: the read returns pre-write contents.
  - RDW_NEW: written bytes return the new data; unwritten bytes return old data.
- Multiple R ports reading the same word is legal; each returns identical data.
- rdata holds its last value while rvalid=0.
- Reset:
  - Outputs go to zero: all rvalid=0, err=0, rdata=0.
  - All in-flight read pipeline stages are flushed; reads issued during rst are ignored.
  - Memory contents are NOT cleared.
  - A write presented while rst=1 is blocked.
- Memory contents are X after power-up until written. The bench preloads via hierarchical $readmemh of the MEM array.
- Elaboration errors:
  - DWIDTH%8 != 0
  - RD_LAT outside 1..4
  - NRD outside 1..4
  - AWIDTH < BLSB+D

Decomposition:
- Package sram_model_pkg holds:
  - typedef enum rdw_mode_e {RDW_OLD, RDW_NEW}
  - function addr_in_range()
  - constants RD_LAT_MAX=4 and NRD_MAX=4
- Sub-module sram_rd_pipe, instantiated NRD+1 times. It is a parametrised RD_LAT-deep shift register carrying {valid, err, data}, with synchronous flush on rst.
- Array storage and collision logic stay in the top module.

Test Plan:
- RD_LAT=1, DWIDTH=32: write 32'hDEADBEEF at 0x10 with mask 4'hF, read 0x10 on the next cycle → a_rvalid the cycle after the read, a_rdata=32'hDEADBEEF, a_err=0.
- Partial write 32'h11223344 mask 4'b0101 over 32'hDEADBEEF, then read with r_mask 4'b1111 → 32'hDE22BE44. Read with r_mask 4'b0011 and MASK_WR_ONLY=0 → 32'h0000BE44.
- RD_LAT=3, NRD=2: issue reads to 0x0,0x4,0x8 on consecutive cycles on port R0, and 0x8 on R1 → R0 valids on cycles +3,+4,+5 in order with the matching data; R1 returns data equal to R0's 0x8 data.
- Collision at 0x20 (old 32'hAAAA_AAAA), A writes 32'h5555_5555 mask 4'b0011 while R0 reads 0x20 → RDW_OLD gives 32'hAAAAAAAA; RDW_NEW gives 32'hAAAA5555.
- WORDS=1000: read byte address 4000 (index 1000) → rvalid=1, err=1, rdata=0. Write to the same address → a_err pulse, no array change.
- RD_LAT=2: issue a read, assert rst for 1 cycle on the next cycle → no rvalid ever appears for that read, outputs are 0. A post-reset read of previously written data returns the preserved value.
